// File: rtl/calc_entry_fsm_if.sv
// calc_entry_fsm_if: the signals between the digit-entry stage, the calculator FSM and the
// display. The entry stage supplies a digit value and a one-cycle enter pulse. The calculator
// drives the multiplexed 7-segment display, the sign LED and a busy flag.
//   digit   : 0-9 valid; 10-15 are ignored by the calculator
//   enter_p : single-cycle capture pulse
//   op_sel  : 00 add, 01 sub, 10 mul, 11 add
//   seg     : active-low segments a..g on bits 6..0
//   an      : active-low digit enables, an[3] is the leftmost digit
//   neg     : sign LED
//   busy    : calculation/conversion in progress
interface calc_entry_fsm_if;
   logic [3:0] digit;
   logic       enter_p;
   logic [1:0] op_sel;
   logic [6:0] seg;
   logic [3:0] an;
   logic       neg;
   logic       busy;

   modport master (output digit, enter_p, op_sel, input seg, an, neg, busy);
   modport slave  (input digit, enter_p, op_sel, output seg, an, neg, busy);
endinterface

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: collects two 2-digit decimal operands and applies add, sub or mul. The
// binary result goes through a 14-step double-dabble into BCD. The module scans a 4-digit
// active-low 7-segment display and drives a sign LED.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : calc_entry_fsm_if.slave (digit/enter_p/op_sel in; seg/an/neg/busy out)
//
// state  | meaning
// A_TENS | waiting for the tens digit of A
// A_ONES | waiting for the ones digit of A
// B_TENS | waiting for the tens digit of B
// B_ONES | waiting for the ones digit of B
// CALC   | one cycle: result computed, loaded into the shift register
// CONV   | 14 double-dabble iterations
// SHOW   | result displayed; any enter returns to A_TENS
module calc_entry_fsm #(
   parameter int REFRESH_DIV = 100000
) (
   input logic          clk,
   input logic          reset,
   calc_entry_fsm_if.slave bus
);
   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [6:0] BLANK = 7'b1111111;

   typedef enum logic [2:0] {A_TENS, A_ONES, B_TENS, B_ONES, CALC, CONV, SHOW} state_t;
   state_t state, state_nx;

   logic [3:0]    a_tens, a_ones, b_tens, b_ones;
   logic [13:0]   bin_sr;
   logic [15:0]   bcd, bcd_adj;
   logic [3:0]    iter;
   logic          neg_r;
   logic [CW-1:0] refresh_cnt;
   logic [1:0]    scan_idx;
   logic          scan_en;

   logic          capture;
   logic [6:0]    a_val, b_val;
   logic [13:0]   mag;
   logic          sub_neg;
   logic [3:0]    disp_dig;
   logic          disp_blank;

   assign capture = bus.enter_p && (bus.digit <= 4'd9);
   assign a_val   = 7'(a_tens) * 7'd10 + 7'(a_ones);
   assign b_val   = 7'(b_tens) * 7'd10 + 7'(b_ones);

   always_comb begin
      mag     = 14'(a_val) + 14'(b_val);
      sub_neg = 1'b0;
      case (bus.op_sel)
         2'b01: begin
            if (a_val >= b_val) begin
               mag = 14'(a_val - b_val);
            end else begin
               mag     = 14'(b_val - a_val);
               sub_neg = 1'b1;
            end
         end
         2'b10:   mag = 14'(a_val) * 14'(b_val);
         default: mag = 14'(a_val) + 14'(b_val);
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         A_TENS:  if (capture) state_nx = A_ONES;
         A_ONES:  if (capture) state_nx = B_TENS;
         B_TENS:  if (capture) state_nx = B_ONES;
         B_ONES:  if (capture) state_nx = CALC;
         CALC:    state_nx = CONV;
         CONV:    if (iter == 4'd13) state_nx = SHOW;
         SHOW:    if (bus.enter_p) state_nx = A_TENS;
         default: state_nx = A_TENS;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= A_TENS;
         a_tens <= '0;
         a_ones <= '0;
         b_tens <= '0;
         b_ones <= '0;
         bin_sr <= '0;
         bcd    <= '0;
         iter   <= '0;
         neg_r  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            A_TENS: if (capture) a_tens <= bus.digit;
            A_ONES: if (capture) a_ones <= bus.digit;
            B_TENS: if (capture) b_tens <= bus.digit;
            B_ONES: if (capture) b_ones <= bus.digit;
            CALC: begin
               bin_sr <= mag;
               bcd    <= '0;
               iter   <= '0;
               neg_r  <= (bus.op_sel == 2'b01) && sub_neg;
            end
            CONV: begin
               {bcd, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
               iter          <= iter + 4'd1;
            end
            SHOW: begin
               if (bus.enter_p) begin
                  a_tens <= '0;
                  a_ones <= '0;
                  b_tens <= '0;
                  b_ones <= '0;
                  bin_sr <= '0;
                  bcd    <= '0;
                  neg_r  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // scan_en holds all anodes off for the first cycle after reset release. The counter
   // also waits that cycle, so index 0 is held for REFRESH_DIV cycles like the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_en     <= 1'b0;
         refresh_cnt <= '0;
         scan_idx    <= '0;
      end else if (!scan_en) begin
         scan_en <= 1'b1;
      end else if (refresh_cnt == CNT_LAST) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + CW'(1);
      end
   end

   always_comb begin
      disp_dig   = 4'd0;
      disp_blank = 1'b1;
      case (state)
         A_TENS, A_ONES: begin
            if (scan_idx == 2'd3) begin disp_dig = a_tens; disp_blank = 1'b0; end
            if (scan_idx == 2'd2) begin disp_dig = a_ones; disp_blank = 1'b0; end
         end
         B_TENS, B_ONES: begin
            disp_blank = 1'b0;
            case (scan_idx)
               2'd3:    disp_dig = a_tens;
               2'd2:    disp_dig = a_ones;
               2'd1:    disp_dig = b_tens;
               default: disp_dig = b_ones;
            endcase
         end
         SHOW: begin
            disp_dig = bcd[{scan_idx, 2'b00} +: 4];
            case (scan_idx)
               2'd3:    disp_blank = (bcd[15:12] == 4'd0);
               2'd2:    disp_blank = (bcd[15:8] == 8'd0);
               2'd1:    disp_blank = (bcd[15:4] == 12'd0);
               default: disp_blank = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b0000001;
         4'd1:    seg_code = 7'b1001111;
         4'd2:    seg_code = 7'b0010010;
         4'd3:    seg_code = 7'b0000110;
         4'd4:    seg_code = 7'b1001100;
         4'd5:    seg_code = 7'b0100100;
         4'd6:    seg_code = 7'b0100000;
         4'd7:    seg_code = 7'b0001111;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0000100;
         default: seg_code = BLANK;
      endcase
   endfunction

   assign bus.seg  = disp_blank ? BLANK : seg_code(disp_dig);
   assign bus.an   = scan_en ? ~(4'b0001 << scan_idx) : 4'b1111;
   assign bus.neg  = (state == SHOW) && neg_r;
   assign bus.busy = (state == CALC) || (state == CONV);
endmodule
